clk_divider_bank: RTL and testbench
===================================

Name: clk_divider_bank

Overview:
- Three independent integer clock dividers driven from the 100 MHz system clock.
- Outputs: 25 MHz (÷4), 625 kHz (÷160), ~596 kHz (÷168, 595.238 kHz).
- Each output is a registered, glitch-free square wave plus a one-cycle tick strobe.
- Used as a fabric clock-enable and slow-clock source; outputs are not intended as global clock nets.

Parameters:
- DIV_25M, 4, divide ratio for channel 0 (100 MHz -> 25 MHz); integer >= 2.
- DIV_625K, 160, divide ratio for channel 1 (100 MHz -> 625 kHz); integer >= 2.
- DIV_596K, 168, divide ratio for channel 2 (100 MHz -> ~596 kHz); integer >= 2.

Ports:
- clk  input  1  100 MHz system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  global count enable; when low, all counters and outputs hold.
- clk_out_25mhz  output  1  channel 0 square wave.
- clk_out_625khz  output  1  channel 1 square wave.
- clk_out_596khz  output  1  channel 2 square wave.
- tick_25mhz  output  1  one-cycle pulse when channel 0 counter wraps.
- tick_625khz  output  1  one-cycle pulse when channel 1 counter wraps.
- tick_596khz  output  1  one-cycle pulse when channel 2 counter wraps.

Behaviour:
- Structure: one generic channel, instantiated three times with N = DIV_x.
  - Counter width is $clog2(N).
  - Elaboration fails if N < 2.
- Reset (rst = 1 at a clk rising edge), regardless of en:
  - every counter goes to 0;
  - every clk_out_* goes to 0;
  - every tick_* goes to 0.
- Counting, per clk edge with rst = 0 and en = 1:
  - cnt_next = (cnt == N-1) ? 0 : cnt+1;
  - cnt <= cnt_next;
  - clk_out <= (cnt_next >= N/2), where N/2 is integer floor division;
  - tick <= (cnt_next == 0).
- Waveform:
  - Low for N/2 cycles, then high for N - N/2 cycles; period is N cycles.
  - Duty cycle is exactly 50% for even N. For odd N the high phase is one cycle longer.
- Edge timing after reset release: count clk edges with rst = 0, en = 1 as edge 1, 2, 3, …
  - First rise of clk_out is at edge N/2; subsequent rises every N edges.
  - First tick is at edge N, lasting one cycle; then every N edges.
- en = 0: cnt, clk_out and tick all hold their values.
  - A tick that was high stays high while en is low.
  - Counting resumes seamlessly when en returns high.
- Mid-operation reset: all channels return to the reset state on that edge and restart phase-aligned. All three rising edges coincide with the post-reset schedule.
- Channels share no state; each ratio is independent. All outputs come directly from flops, with no combinational paths to outputs.

Test Plan:
- Reset: hold rst = 1 for 5 cycles with en = 1 -> all six outputs are 0 on every edge and all counters are 0.
- 25 MHz channel: release rst, en = 1 -> clk_out_25mhz sequence from edge 1 is 0,1,1,0,0,1,1,0,…; tick_25mhz is high at edges 4, 8, 12, ….
- 625k/596k phase: after release, clk_out_625khz first rises at edge 80 and falls at edge 160; clk_out_596khz first rises at edge 84 and falls at edge 168; ticks occur at edges 160 and 168.
- Long run: 50000 edges after release -> rising-edge counts are 12500 (25 MHz), 313 (625 kHz) and 298 (596 kHz). Measured periods are exactly 4, 160 and 168 cycles.
- Enable hold: deassert en at edge 100 for 37 cycles -> all outputs and counters freeze. After re-enable, every subsequent edge is shifted by exactly 37 cycles.
- Mid-run reset: assert rst for 1 cycle at edge 1000 -> all outputs are 0 on the next edge. The edge schedule restarts as in the 25 MHz and 625k/596k phase scenarios, counted from the edge after rst deasserts.

Source files
------------

// File: rtl/clk_divider_bank_if.sv
// Bundle of the divider bank's enable input and its six registered outputs.
// master drives en and observes the outputs; slave is the divider bank.
interface clk_divider_bank_if;
    logic en;
    logic clk_out_25mhz;
    logic clk_out_625khz;
    logic clk_out_596khz;
    logic tick_25mhz;
    logic tick_625khz;
    logic tick_596khz;

    modport master (
        output en,
        input  clk_out_25mhz,
        input  clk_out_625khz,
        input  clk_out_596khz,
        input  tick_25mhz,
        input  tick_625khz,
        input  tick_596khz
    );

    modport slave (
        input  en,
        output clk_out_25mhz,
        output clk_out_625khz,
        output clk_out_596khz,
        output tick_25mhz,
        output tick_625khz,
        output tick_596khz
    );
endinterface

// File: rtl/clk_divider_bank.sv
// Three independent integer clock dividers producing registered square
// waves and one-cycle wrap ticks, usable as fabric clock enables.
module clk_div_channel #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic clk_out,
    output logic tick
);
    localparam int W = (N < 2) ? 1 : $clog2(N);

    generate
        if (N < 2) begin : g_bad_ratio
            $error("clk_div_channel: divide ratio N must be >= 2");
        end
    endgenerate

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] HALF = W'(N / 2);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;

    // Next count wraps to zero after N-1.
    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + ONE;
    end

    // Counter and output flops; everything holds while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (en) begin
            cnt     <= cnt_next;
            clk_out <= (cnt_next >= HALF);
            tick    <= (cnt_next == '0);
        end
    end
endmodule

module clk_divider_bank #(
    parameter int DIV_25M  = 4,
    parameter int DIV_625K = 160,
    parameter int DIV_596K = 168
) (
    input  logic                  clk,
    input  logic                  rst,
    clk_divider_bank_if.slave     bus
);
    clk_div_channel #(.N(DIV_25M)) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .clk_out (bus.clk_out_25mhz),
        .tick    (bus.tick_25mhz)
    );

    clk_div_channel #(.N(DIV_625K)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .clk_out (bus.clk_out_625khz),
        .tick    (bus.tick_625khz)
    );

    clk_div_channel #(.N(DIV_596K)) u_ch2 (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .clk_out (bus.clk_out_596khz),
        .tick    (bus.tick_596khz)
    );
endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench for clk_divider_bank: vector table, phase corners,
// enable hold, mid-run reset, random en/rst against a model, long run.
module tb_clk_divider_bank;
    localparam int N0 = 4;
    localparam int N1 = 160;
    localparam int N2 = 168;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_divider_bank_if bus();

    clk_divider_bank #(
        .DIV_25M  (N0),
        .DIV_625K (N1),
        .DIV_596K (N2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // Enabled edges seen since the last reset; the whole model hangs off it.
    int k = 0;

    typedef struct {
        logic rst;
        logic en;
        logic ck;
        logic tk;
    } vec_t;

    vec_t tbl[14];

    // {out25, out625, out596, tick25, tick625, tick596}
    function automatic logic [5:0] model_out();
        logic [2:0] o;
        logic [2:0] t;
        int n[3];
        n[0] = N0;
        n[1] = N1;
        n[2] = N2;
        for (int i = 0; i < 3; i++) begin
            o[2-i] = ((k % n[i]) >= (n[i] / 2));
            t[2-i] = (k > 0) && ((k % n[i]) == 0);
        end
        return {o, t};
    endfunction

    function automatic logic [5:0] dut_out();
        return {bus.clk_out_25mhz, bus.clk_out_625khz, bus.clk_out_596khz,
                bus.tick_25mhz, bus.tick_625khz, bus.tick_596khz};
    endfunction

    task automatic step(input logic r, input logic e);
        rst    = r;
        bus.en = e;
        @(posedge clk);
        #1;
        if (r) k = 0;
        else if (e) k++;
    endtask

    task automatic check6(input string name, input logic [5:0] act,
                          input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%b expected=%b", name, k, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%b expected=%b", name, k, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin
        logic [5:0] snap;
        int rises[3];
        int last[3];
        int badp[3];
        logic [2:0] prev;
        logic [2:0] cur;
        int n[3];

        n[0] = N0;
        n[1] = N1;
        n[2] = N2;
        bus.en = 1'b1;

        // Reset held for 5 cycles with en high
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            check6("reset", dut_out(), 6'b0);
        end

        // Table of 25 MHz vectors: counting, hold, reset, restart
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].en);
            check1("tbl_clk25", bus.clk_out_25mhz, tbl[i].ck);
            check1("tbl_tick25", bus.tick_25mhz, tbl[i].tk);
        end

        // 625k / 596k phase corners after release
        step(1'b1, 1'b1);
        for (int e = 1; e <= 170; e++) begin
            step(1'b0, 1'b1);
            if (e == 79)  check1("c625_pre_rise", bus.clk_out_625khz, 1'b0);
            if (e == 80)  check1("c625_rise", bus.clk_out_625khz, 1'b1);
            if (e == 83)  check1("c596_pre_rise", bus.clk_out_596khz, 1'b0);
            if (e == 84)  check1("c596_rise", bus.clk_out_596khz, 1'b1);
            if (e == 159) check1("t625_early", bus.tick_625khz, 1'b0);
            if (e == 160) check1("c625_fall", bus.clk_out_625khz, 1'b0);
            if (e == 160) check1("t625", bus.tick_625khz, 1'b1);
            if (e == 161) check1("t625_one", bus.tick_625khz, 1'b0);
            if (e == 167) check1("c596_high", bus.clk_out_596khz, 1'b1);
            if (e == 168) check1("c596_fall", bus.clk_out_596khz, 1'b0);
            if (e == 168) check1("t596", bus.tick_596khz, 1'b1);
            if (e == 169) check1("t596_one", bus.tick_596khz, 1'b0);
        end

        // Enable hold: en low for 37 cycles after edge 100
        step(1'b1, 1'b1);
        for (int e = 1; e <= 100; e++) step(1'b0, 1'b1);
        snap = dut_out();
        check6("hold_model", snap, model_out());
        for (int e = 0; e < 37; e++) begin
            step(1'b0, 1'b0);
            check6("hold_freeze", dut_out(), snap);
        end
        for (int c = 138; c <= 400; c++) begin
            step(1'b0, 1'b1);
            check6("hold_resume", dut_out(), model_out());
            if (c == 197) check1("hold_t625", bus.tick_625khz, 1'b1);
            if (c == 205) check1("hold_t596", bus.tick_596khz, 1'b1);
        end

        // Mid-run reset at edge 1000
        step(1'b1, 1'b1);
        for (int e = 1; e < 1000; e++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check6("midrst", dut_out(), 6'b0);
        for (int e = 1; e <= 170; e++) begin
            step(1'b0, 1'b1);
            check6("midrst_run", dut_out(), model_out());
            if (e == 80) check1("midrst_c625", bus.clk_out_625khz, 1'b1);
            if (e == 84) check1("midrst_c596", bus.clk_out_596khz, 1'b1);
        end

        // Random en / rst against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
            check6("random", dut_out(), model_out());
        end

        // Long run: 50000 enabled edges, count rises and measure periods
        step(1'b1, 1'b1);
        prev = 3'b000;
        for (int i = 0; i < 3; i++) begin
            rises[i] = 0;
            last[i]  = -1;
            badp[i]  = 0;
        end
        for (int e = 1; e <= 50000; e++) begin
            step(1'b0, 1'b1);
            cur = {bus.clk_out_25mhz, bus.clk_out_625khz, bus.clk_out_596khz};
            for (int i = 0; i < 3; i++) begin
                if (cur[2-i] && !prev[2-i]) begin
                    rises[i]++;
                    if (last[i] >= 0 && (e - last[i]) != n[i]) badp[i]++;
                    last[i] = e;
                end
            end
            prev = cur;
        end
        checki("rises_25m", rises[0], 12500);
        checki("rises_625k", rises[1], 313);
        checki("rises_596k", rises[2], 298);
        checki("badper_25m", badp[0], 0);
        checki("badper_625k", badp[1], 0);
        checki("badper_596k", badp[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
